// File: rtl/adder_unit_pkg.sv
// Shared word-length and lookahead-group defaults for the execution-stage adder.
// No logic; constants only.
// No flow control.
package adder_unit_pkg;

    localparam int WORD_LENGTH = 24;
    localparam int GROUP_BITS  = 4;

endpackage

// File: rtl/cla_group.sv
// One carry-lookahead slice: sum bits plus group generate/propagate and carry-out.
// Purely combinational, zero latency.
// No flow control.
module cla_group
    import adder_unit_pkg::*;
#(
    parameter int W = GROUP_BITS
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         gg,
    output logic         gp,
    output logic         cout
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] carry;
    logic         c_prod;
    logic         g_prod;

    assign g = a & b;
    assign p = a ^ b;

    // Each bit carry is a flat sum-of-products of lower generates, not a ripple.
    always_comb begin
        carry  = '0;
        c_prod = 1'b1;
        for (int i = 0; i < W; i++) begin
            c_prod = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                carry[i] = carry[i] | (g[j] & c_prod);
                c_prod   = c_prod & p[j];
            end
            carry[i] = carry[i] | (cin & c_prod);
        end
    end

    always_comb begin
        gg     = 1'b0;
        g_prod = 1'b1;
        for (int j = W - 1; j >= 0; j--) begin
            gg     = gg | (g[j] & g_prod);
            g_prod = g_prod & p[j];
        end
    end

    assign gp   = &p;
    assign cout = gg | (gp & cin);
    assign sum  = p ^ carry;

endmodule

// File: rtl/adder_unit.sv
// Registered WIDTH-bit adder a + b + in_c with carry-out and signed overflow.
// Latency 1 cycle, one result per clock; no backpressure, outputs hold when in_valid is low.
// Operand/result vectors are MSB-first ([0:WIDTH-1]); arithmetic is done on LSB-first copies.
module adder_unit
    import adder_unit_pkg::*;
#(
    parameter int WIDTH = WORD_LENGTH,
    parameter int GROUP = GROUP_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    input  logic             in_c,
    output logic [0:WIDTH-1] s,
    output logic             out_c,
    output logic             ovf,
    output logic             out_valid
);

    localparam int NG = WIDTH / GROUP;

    logic [WIDTH-1:0] a_le;
    logic [WIDTH-1:0] b_le;
    logic [WIDTH-1:0] sum_le;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG-1:0]    grp_cin;
    logic [NG-1:0]    grp_cout;
    logic             carry_out;
    logic             la_prod;
    logic             overflow;

    // Packed assignment keeps numeric value: a[0] lands on a_le[WIDTH-1].
    assign a_le       = a;
    assign b_le       = b;
    assign grp_cin[0] = in_c;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group #(.W(GROUP)) u_grp (
            .a    (a_le[k*GROUP +: GROUP]),
            .b    (b_le[k*GROUP +: GROUP]),
            .cin  (grp_cin[k]),
            .sum  (sum_le[k*GROUP +: GROUP]),
            .gg   (grp_g[k]),
            .gp   (grp_p[k]),
            .cout (grp_cout[k])
        );
        if (k > 0) begin : g_chain
            assign grp_cin[k] = grp_cout[k-1];
        end
    end

    // Word carry-out straight from group G/P so it does not wait on the ripple.
    always_comb begin
        carry_out = 1'b0;
        la_prod   = 1'b1;
        for (int k = NG - 1; k >= 0; k--) begin
            carry_out = carry_out | (grp_g[k] & la_prod);
            la_prod   = la_prod & grp_p[k];
        end
        carry_out = carry_out | (in_c & la_prod);
    end

    // Carry into the MSB is p ^ sum there; XOR with the MSB group's carry-out.
    assign overflow = a_le[WIDTH-1] ^ b_le[WIDTH-1] ^ sum_le[WIDTH-1] ^ grp_cout[NG-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= '0;
            out_c     <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s     <= sum_le;
                out_c <= carry_out;
                ovf   <= overflow;
            end
        end
    end

endmodule

// File: tb/tb_adder_unit.sv
// Directed and random self-checking bench for adder_unit (WIDTH 24, GROUP 4).
module tb_adder_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [0:23] a;
    logic [0:23] b;
    logic        in_c;
    logic [0:23] s;
    logic        out_c;
    logic        ovf;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    adder_unit #(.WIDTH(24), .GROUP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .in_c      (in_c),
        .s         (s),
        .out_c     (out_c),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Directed vectors: a, b, in_c, expected s, out_c, ovf (hand-computed).
    typedef struct {
        logic [23:0] va;
        logic [23:0] vb;
        logic        vc;
        logic [23:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{24'h000000, 24'h000000, 1'b0, 24'h000000, 1'b0, 1'b0};
        vecs[1] = '{24'h00000A, 24'h000005, 1'b0, 24'h00000F, 1'b0, 1'b0};
        vecs[2] = '{24'h000000, 24'h000005, 1'b0, 24'h000005, 1'b0, 1'b0};
        vecs[3] = '{24'h00000A, 24'h00001F, 1'b1, 24'h00002A, 1'b0, 1'b0};
        vecs[4] = '{24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1, 1'b0};
        vecs[5] = '{24'h7FFFFF, 24'h000001, 1'b0, 24'h800000, 1'b0, 1'b1};
        vecs[6] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 24'hFFFFFF, 1'b1, 1'b0};
        vecs[7] = '{24'h800000, 24'h800000, 1'b0, 24'h000000, 1'b1, 1'b1};
    end

    initial begin
        logic [23:0] ra;
        logic [23:0] rb;
        logic        rc;
        logic [24:0] tot;
        logic        eo;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        in_c     = 1'b0;

        #12;
        check("reset_s", 32'(s), 32'h0);
        check("reset_flags", {29'h0, out_c, ovf, out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back directed vectors: drive just after an edge, check after the next.
        for (int i = 0; i < 8; i++) begin
            a        = vecs[i].va;
            b        = vecs[i].vb;
            in_c     = vecs[i].vc;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_s", i), 32'(s), 32'(vecs[i].es));
            check($sformatf("vec%0d_c", i), 32'(out_c), 32'(vecs[i].ec));
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].eo));
            check($sformatf("vec%0d_vld", i), 32'(out_valid), 32'h1);
        end

        // Hold: new operands with in_valid low must not disturb the last result.
        for (int i = 0; i < 2; i++) begin
            a        = 24'h123456 + 24'(i);
            b        = 24'h7FFFFF;
            in_c     = 1'b1;
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_s", i), 32'(s), 32'h000000);
            check($sformatf("hold%0d_flags", i), {29'h0, out_c, ovf, out_valid}, 32'h6);
        end

        // Asynchronous reset mid-cycle with a result held.
        a        = 24'h7FFFFF;
        b        = 24'h000001;
        in_c     = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_s", 32'(s), 32'h800000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_s", 32'(s), 32'h0);
        check("async_rst_flags", {29'h0, out_c, ovf, out_valid}, 32'h0);
        #3;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_s", 32'(s), 32'h0);
        check("post_rst_flags", {29'h0, out_c, ovf, out_valid}, 32'h0);

        // Random back-to-back traffic against a behavioural sum.
        for (int i = 0; i < 1000; i++) begin
            ra  = 24'($urandom);
            rb  = 24'($urandom);
            rc  = 1'($urandom);
            tot = {1'b0, ra} + {1'b0, rb} + 25'(rc);
            eo  = (ra[23] == rb[23]) && (tot[23] != ra[23]);
            a        = ra;
            b        = rb;
            in_c     = rc;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("rand%0d", i), {5'h0, out_valid, out_c, ovf, s},
                  {5'h0, 1'b1, tot[24], eo, tot[23:0]});
        end

        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("final_vld", 32'(out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_unit.md
Name: adder_unit

Overview:
- Registered WIDTH-bit binary adder with carry-in, carry-out and signed-overflow flag.
- Arithmetic core of the execution-stage ALU; computes a + b + in_c.
- Result captured in an output register one clock after a valid input.
- Combinational core built from carry-lookahead groups so timing scales to word length.

Parameters:
- WIDTH, 24, operand/result width in bits (word length); any multiple of 4, minimum 4.
- GROUP, 4, bits per carry-lookahead group; WIDTH must be a multiple of GROUP.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid this cycle; result captured on this edge.
- a  input  WIDTH  operand A, bit 0 = MSB (vector declared [0:WIDTH-1]).
- b  input  WIDTH  operand B, same ordering.
- in_c  input  1  carry-in, added at LSB (bit WIDTH-1).
- s  output  WIDTH  registered sum, bit 0 = MSB.
- out_c  output  1  registered carry-out of the MSB.
- ovf  output  1  registered signed (two's-complement) overflow.
- out_valid  output  1  s/out_c/ovf hold a fresh result.

Interface (already decided): one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.

Behaviour:
- Reset (rst_n low, any time, independent of clk): s = 0, out_c = 0, ovf = 0, out_valid = 0 immediately. All values held until the first rising edge after rst_n deasserts.
- Arithmetic: {out_c, s} = a + b + in_c, computed unsigned, WIDTH+1 bits, no saturation. Wrap-around modulo 2^WIDTH, with the lost bit reported on out_c.
- ovf = carry into MSB XOR carry out of MSB, equivalently (a[0] == b[0]) && (s[0] != a[0]).
- Latency: exactly 1 cycle.
- When in_valid is high at a rising edge, s, out_c and ovf load the new result and out_valid goes to 1 on that edge.
- When in_valid is low at a rising edge, s, out_c and ovf hold their previous values and out_valid goes to 0.
- Back-to-back: in_valid may be high every cycle; throughput is one result per clock. No stall or backpressure.
- Reset mid-operation: an in-flight result is discarded; outputs return to reset values.
- Carry structure:
  - Per-bit generate g = a&b and propagate p = a^b.
  - Each GROUP-bit group produces group G/P and internal carries by lookahead.
  - Group carries ripple or lookahead across groups (implementer's choice).
  - Sum bit = p XOR carry-in of that bit.
  - A plain "+" operator is not used for the core, so the structure is visible for timing.
- X on inputs while in_valid is low must not corrupt the held outputs.

Decomposition:
- Shared package holds WORD_LENGTH = 24 (default for WIDTH) and the GROUP default constant. No typedefs needed.
- One sub-module, cla_group: GROUP-bit carry-lookahead slice.
  - Inputs: a, b, cin.
  - Outputs: sum, group generate, group propagate, cout.
  - Instantiated WIDTH/GROUP times via generate loop.
- Top level contains the group chain, the overflow logic and the output register.

Test Plan:
- Reset: drive rst_n low mid-cycle with a prior result held -> s = 0x000000, out_c = 0, ovf = 0, out_valid = 0 immediately, without a clock edge.
- a = 0x000000, b = 0x000000, in_c = 0, in_valid = 1 -> next edge s = 0x000000, out_c = 0, ovf = 0.
- a = 10, b = 5, in_c = 0 -> s = 0x00000F, out_c = 0. Then a = 0, b = 5 -> s = 0x000005, out_c = 0 on the following cycle (back-to-back).
- a = 10, b = 31, in_c = 1 -> s = 0x00002A, out_c = 0, ovf = 0.
- a = 0xFFFFFF, b = 1, in_c = 0 -> s = 0x000000, out_c = 1, ovf = 0. Then a = 0x7FFFFF, b = 1 -> s = 0x800000, out_c = 0, ovf = 1.
- Hold and random check:
  - Drop in_valid with different a/b applied -> s/out_c/ovf unchanged, out_valid = 0.
  - Then 1000 random a/b/in_c with in_valid = 1 -> every result matches a + b + in_c one cycle later.
